// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory arbiter:
// FSM state encoding, default bus widths and the supported core count range.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } imem_state_e;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;
    localparam int MIN_CORES  = 2;
    localparam int MAX_CORES  = 8;

endpackage

// File: rtl/imem_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first set request at or after ptr,
// wrapping modulo NUM_CORES, wins.
module rr_arbiter #(
    parameter  int NUM_CORES = 4,
    localparam int IDX_W     = $clog2(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic                 valid,
    output logic [IDX_W-1:0]     winner
);

    int idx;

    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = 0;
        // Walk from the farthest offset back toward ptr so the nearest requester is written last.
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_CORES;
            if (req[idx]) begin
                valid  = 1'b1;
                winner = idx[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Round-robin sharing of a single-port instruction RAM among NUM_CORES fetch units.
// Each access holds RD/ADDBUS for two cycles, then pulses the winner's ack for one cycle.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter  int NUM_CORES = 4,
    parameter  int ADDR_W    = DEF_ADDR_W,
    parameter  int DATA_W    = DEF_DATA_W,
    localparam int IDX_W     = $clog2(NUM_CORES)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CORES-1:0]        core_req,
    input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
    output logic [NUM_CORES-1:0]        core_ack,
    output logic [DATA_W-1:0]           core_rdata,
    output logic                        mem_rd,
    output logic [ADDR_W-1:0]           mem_addr,
    input  logic [DATA_W-1:0]           mem_dataout,
    output logic                        busy,
    output logic [IDX_W-1:0]            grant_id,
    output imem_state_e                 dbg_state
);

    imem_state_e          state_q, state_d;
    logic                 phase_q, phase_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 rd_q, rd_d;
    logic [NUM_CORES-1:0] ack_q, ack_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;

    logic                 arb_valid;
    logic [IDX_W-1:0]     arb_winner;
    logic                 arbitrate;
    logic                 read_close;

    rr_arbiter #(.NUM_CORES(NUM_CORES)) u_rr (
        .req    (core_req),
        .ptr    (rr_ptr_q),
        .valid  (arb_valid),
        .winner (arb_winner)
    );

    // DONE arbitrates like IDLE so back-to-back fetches need no dead cycle.
    assign arbitrate  = ((state_q == IDLE) || (state_q == DONE)) && arb_valid;
    assign read_close = (state_q == READ) && phase_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            phase_q  <= 1'b0;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            addr_q   <= '0;
            rd_q     <= 1'b0;
            ack_q    <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            addr_q   <= addr_d;
            rd_q     <= rd_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        case (state_q)
            IDLE: begin
                phase_d = 1'b0;
                if (arb_valid) state_d = READ;
            end
            READ: begin
                if (phase_q) begin
                    state_d = DONE;
                    phase_d = 1'b0;
                end else begin
                    phase_d = 1'b1;
                end
            end
            DONE: begin
                phase_d = 1'b0;
                state_d = arb_valid ? READ : IDLE;
            end
            default: begin
                state_d = IDLE;
                phase_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        grant_d  = grant_q;
        addr_d   = addr_q;
        rd_d     = rd_q;
        ack_d    = '0;
        rdata_d  = rdata_q;
        rr_ptr_d = rr_ptr_q;
        if (arbitrate) begin
            grant_d = arb_winner;
            addr_d  = core_addr[int'(arb_winner)*ADDR_W +: ADDR_W];
            rd_d    = 1'b1;
        end
        if (read_close) begin
            rdata_d        = mem_dataout;
            rd_d           = 1'b0;
            ack_d[grant_q] = 1'b1;
            rr_ptr_d       = (int'(grant_q) == NUM_CORES - 1) ? '0 : grant_q + 1'b1;
        end
    end

    assign core_ack   = ack_q;
    assign core_rdata = rdata_q;
    assign mem_rd     = rd_q;
    assign mem_addr   = addr_q;
    assign busy       = (state_q != IDLE);
    assign grant_id   = grant_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: ack/data scoreboard checked by a negedge monitor,
// plus cycle-exact checks of the RAM strobe, address and grant.
module tb_imem_arbiter;
    import imem_pkg::*;

    localparam int NC = 4;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NC-1:0]     core_req;
    logic [NC*AW-1:0]  core_addr;
    logic [NC-1:0]     core_ack;
    logic [DW-1:0]     core_rdata;
    logic              mem_rd;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_dataout;
    logic              busy;
    logic [IW-1:0]     grant_id;
    imem_state_e       dbg_state;

    int                checks = 0;
    int                errors = 0;
    logic [NC+DW-1:0]  exp_q[$];
    logic [NC+DW-1:0]  sb_exp;
    logic [NC-1:0]     got_ack;
    int                got_cyc;

    imem_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .core_req    (core_req),
        .core_addr   (core_addr),
        .core_ack    (core_ack),
        .core_rdata  (core_rdata),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_dataout (mem_dataout),
        .busy        (busy),
        .grant_id    (grant_id),
        .dbg_state   (dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // RAM model: drives a junk pattern while RD is low
    function automatic logic [DW-1:0] ram(input logic [AW-1:0] a);
        case (a)
            16'd1:   ram = 16'd52;
            16'd2:   ram = 16'd18;
            16'd3:   ram = 16'd96;
            16'd4:   ram = 16'd112;
            16'd5:   ram = 16'd183;
            16'd7:   ram = 16'd182;
            16'd9:   ram = 16'd77;
            default: ram = a ^ 16'hA5A5;
        endcase
    endfunction

    assign mem_dataout = mem_rd ? ram(mem_addr) : 16'hDEAD;

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic set_addr(input int c, input logic [AW-1:0] a);
        core_addr[c*AW +: AW] = a;
    endtask

    task automatic push_exp(input logic [NC-1:0] ack, input logic [DW-1:0] data);
        exp_q.push_back({ack, data});
    endtask

    task automatic wait_ack(input string name, input int budget, output logic [NC-1:0] ack, output int cyc);
        ack = '0;
        cyc = 0;
        while (cyc < budget && ack == '0) begin
            tick();
            cyc++;
            ack = core_ack;
        end
        if (ack == '0) begin
            checks++;
            errors++;
            $display("FAIL %s: no core_ack within %0d cycles", name, budget);
        end
    endtask

    task automatic serve_one(input string name, input logic [NC-1:0] exp_ack);
        logic [NC-1:0] a;
        int            c;
        wait_ack(name, 20, a, c);
        chk(name, a, exp_ack);
        core_req = core_req & ~a;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (core_ack != '0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_ack: unexpected ack=%b rdata=%0d, expected no ack", core_ack, core_rdata);
            end else begin
                sb_exp = exp_q.pop_front();
                if ({core_ack, core_rdata} !== sb_exp) begin
                    errors++;
                    $display("FAIL sb_ack: got ack=%b rdata=%0d, expected ack=%b rdata=%0d",
                             core_ack, core_rdata, sb_exp[NC+DW-1:DW], sb_exp[DW-1:0]);
                end
            end
        end
    end

    // Stimulus
    initial begin
        rst       = 1'b1;
        core_req  = '0;
        core_addr = '0;
        set_addr(0, 16'h0010);
        set_addr(1, 16'h0011);
        set_addr(2, 16'h0012);
        set_addr(3, 16'h0013);
        core_req = 4'b1111;

        // Reset with every core requesting
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_mem_rd", mem_rd, 0);
            chk("rst_ack", core_ack, 0);
            chk("rst_busy", busy, 0);
            chk("rst_addr", mem_addr, 0);
            chk("rst_rdata", core_rdata, 0);
            chk("rst_grant", grant_id, 0);
        end
        rst = 1'b0;
        push_exp(4'b0001, 16'hA5B5);
        tick();
        chk("post_rst_rd", mem_rd, 1);
        chk("post_rst_grant", grant_id, 0);
        chk("post_rst_addr", mem_addr, 16'h0010);
        chk("post_rst_busy", busy, 1);
        core_req = 4'b0001;
        serve_one("post_rst_ack", 4'b0001);

        // Single fetch from core 2
        tick();
        tick();
        chk("idle_rd", mem_rd, 0);
        chk("idle_busy", busy, 0);
        set_addr(2, 16'd5);
        core_req = 4'b0100;
        push_exp(4'b0100, 16'd183);
        tick();
        chk("single_rd1", mem_rd, 1);
        chk("single_addr1", mem_addr, 5);
        chk("single_grant", grant_id, 2);
        tick();
        chk("single_rd2", mem_rd, 1);
        chk("single_addr2", mem_addr, 5);
        chk("single_ack_early", core_ack, 0);
        tick();
        chk("single_ack", core_ack, 4'b0100);
        chk("single_rdata", core_rdata, 183);
        chk("single_rd_off", mem_rd, 0);
        core_req = '0;
        tick();
        chk("single_ack_clear", core_ack, 0);
        chk("single_rdata_hold", core_rdata, 183);
        chk("single_idle", busy, 0);

        // Fairness: all cores continuously, pointer from 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_addr(0, 16'd1);
        set_addr(1, 16'd2);
        set_addr(2, 16'd3);
        set_addr(3, 16'd4);
        push_exp(4'b0001, 16'd52);
        push_exp(4'b0010, 16'd18);
        push_exp(4'b0100, 16'd96);
        push_exp(4'b1000, 16'd112);
        push_exp(4'b0001, 16'd52);
        push_exp(4'b0010, 16'd18);
        core_req = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            wait_ack("fair_wait", 20, got_ack, got_cyc);
            chk("fair_order", got_ack, 32'd1 << (k % 4));
            chk("fair_period", got_cyc, 3);
        end
        core_req = '0;
        tick();

        // Pointer skip: core 1 served last, cores 0 and 3 request
        set_addr(0, 16'd20);
        set_addr(3, 16'd30);
        core_req = 4'b1001;
        push_exp(4'b1000, 16'hA5BB);
        push_exp(4'b0001, 16'hA5B1);
        serve_one("skip_first", 4'b1000);
        serve_one("skip_second", 4'b0001);
        tick();

        // Reset in the middle of an access
        set_addr(1, 16'd2);
        set_addr(0, 16'd40);
        core_req = 4'b0010;
        tick();
        chk("midrst_grant", grant_id, 1);
        chk("midrst_rd", mem_rd, 1);
        rst = 1'b1;
        tick();
        chk("midrst_rd_off", mem_rd, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ack", core_ack, 0);
        chk("midrst_addr", mem_addr, 0);
        chk("midrst_rdata", core_rdata, 0);
        rst = 1'b0;
        core_req = 4'b1111;
        push_exp(4'b0001, 16'hA58D);
        tick();
        chk("midrst_ptr", grant_id, 0);
        chk("midrst_addr2", mem_addr, 40);
        core_req = 4'b0001;
        serve_one("midrst_serve", 4'b0001);
        tick();

        // Address changes after grant are ignored
        set_addr(0, 16'd7);
        core_req = 4'b0001;
        push_exp(4'b0001, 16'd182);
        tick();
        chk("addrchg_grant", grant_id, 0);
        chk("addrchg_addr1", mem_addr, 7);
        set_addr(0, 16'd9);
        tick();
        chk("addrchg_addr2", mem_addr, 7);
        chk("addrchg_rd", mem_rd, 1);
        serve_one("addrchg_ack", 4'b0001);
        chk("addrchg_rdata", core_rdata, 182);

        repeat (3) tick();
        chk("sb_drained", exp_q.size(), 0);

        // Final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
